// File: rtl/tcp_rx_parser.sv
// rtl/tcp_rx_parser.sv - TCP segment parser: header/metadata extraction, payload forwarding, checksum check
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_axis_t{data,valid,ready,last} input byte stream: TCP header + options + payload
//   m_axis_t{data,valid,ready,last} output byte stream: payload only, tlast on final payload byte
//   meta_valid / meta_ready         metadata FIFO head handshake
//   meta_*                          head entry fields (zero while the FIFO is empty)
//   drop_cnt                        packets dropped (malformed or filtered), wrapping
module tcp_rx_parser #(
    parameter int          DATA_WIDTH  = 8,
    parameter int          META_DEPTH  = 4,
    parameter int          FILTER_EN   = 0,
    parameter logic [15:0] FILTER_PORT = 16'd80
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  meta_valid,
    input  logic                  meta_ready,
    output logic [15:0]           meta_src_port,
    output logic [15:0]           meta_dst_port,
    output logic [31:0]           meta_seq_num,
    output logic [31:0]           meta_ack_num,
    output logic [7:0]            meta_flags,
    output logic [15:0]           meta_window_size,
    output logic [5:0]            meta_hdr_len,
    output logic [15:0]           meta_payload_len,
    output logic                  meta_checksum_ok,
    output logic                  meta_err,
    output logic [15:0]           drop_cnt
);

    generate
        if (DATA_WIDTH != 8) begin : g_bad_width
            $error("tcp_rx_parser: DATA_WIDTH must be 8");
        end
        if (META_DEPTH < 2 || (META_DEPTH & (META_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("tcp_rx_parser: META_DEPTH must be a power of two >= 2");
        end
    endgenerate

    localparam logic [1:0] ST_HDR  = 2'd0;
    localparam logic [1:0] ST_OPT  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    localparam int ADDR_W = $clog2(META_DEPTH);
    localparam int META_W = 144;

    logic [1:0]  state;
    logic [4:0]  byte_idx;
    logic [5:0]  opt_left;
    logic        drop_push;     // dropped packet still owes a metadata entry (malformed, not filtered)
    logic [15:0] src_r, dst_r, win_r, pay_cnt;
    logic [31:0] seq_r, ack_r, csum_acc;
    logic [3:0]  doff_r;
    logic [7:0]  flags_r;
    logic        odd_byte;

    logic [15:0] src_n, dst_n, win_n, pay_inc, plen_n;
    logic [31:0] seq_n, ack_n, csum_nxt;
    logic [3:0]  doff_n;
    logic [7:0]  flags_n, din;
    logic [16:0] fold1, fold2;
    logic        csum_ok, hdr_end, filter_hit, push_want, entry_err;
    logic        s_fire, push, pop, fifo_full, fifo_blocked, tlast_blocked;

    logic [META_W-1:0] mem [META_DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr;
    logic [META_W-1:0] entry;

    assign din = s_axis_tdata[7:0];

    // Header bytes land in their fields as they arrive; the next-values are also
    // what a tlast beat pushes, so a final header byte is never lost.
    always_comb begin
        src_n   = src_r;
        dst_n   = dst_r;
        seq_n   = seq_r;
        ack_n   = ack_r;
        doff_n  = doff_r;
        flags_n = flags_r;
        win_n   = win_r;
        if (state == ST_HDR) begin
            case (byte_idx)
                5'd0:  src_n[15:8]   = din;
                5'd1:  src_n[7:0]    = din;
                5'd2:  dst_n[15:8]   = din;
                5'd3:  dst_n[7:0]    = din;
                5'd4:  seq_n[31:24]  = din;
                5'd5:  seq_n[23:16]  = din;
                5'd6:  seq_n[15:8]   = din;
                5'd7:  seq_n[7:0]    = din;
                5'd8:  ack_n[31:24]  = din;
                5'd9:  ack_n[23:16]  = din;
                5'd10: ack_n[15:8]   = din;
                5'd11: ack_n[7:0]    = din;
                5'd12: doff_n        = din[7:4];
                5'd13: flags_n       = din;
                5'd14: win_n[15:8]   = din;
                5'd15: win_n[7:0]    = din;
                default: ;
            endcase
        end
    end

    // Even packet offsets are the high byte of a 16-bit word, odd ones the low byte.
    assign csum_nxt = csum_acc + (odd_byte ? {24'd0, din} : {16'd0, din, 8'd0});
    assign fold1    = {1'b0, csum_nxt[15:0]} + {1'b0, csum_nxt[31:16]};
    assign fold2    = {1'b0, fold1[15:0]} + {16'd0, fold1[16]};
    assign csum_ok  = (fold2[15:0] == 16'hFFFF);

    assign pay_inc    = (pay_cnt == 16'hFFFF) ? pay_cnt : pay_cnt + 16'd1;
    assign plen_n     = (state == ST_PAY) ? pay_inc : 16'd0;
    assign hdr_end    = (state == ST_HDR) && (byte_idx == 5'd19);
    assign filter_hit = (FILTER_EN != 0) && (dst_r != FILTER_PORT);

    // What a tlast beat in the current state would do: push an entry, and whether it is an error.
    always_comb begin
        push_want = 1'b1;
        entry_err = 1'b0;
        case (state)
            ST_HDR: begin
                push_want = !(hdr_end && filter_hit);
                entry_err = !(hdr_end && doff_r == 4'd5);
            end
            ST_OPT:  entry_err = (opt_left != 6'd1);
            ST_PAY:  entry_err = 1'b0;
            default: begin
                push_want = drop_push;
                entry_err = 1'b1;
            end
        endcase
    end

    assign pop           = meta_valid && meta_ready;
    assign fifo_full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign fifo_blocked  = fifo_full && !pop;
    assign tlast_blocked = s_axis_tlast && push_want && fifo_blocked;

    assign s_axis_tready = rst_n && !tlast_blocked && ((state != ST_PAY) || m_axis_tready);
    // Valid is withheld on a stalled tlast so the output never handshakes a byte the input refused.
    assign m_axis_tvalid = (state == ST_PAY) && s_axis_tvalid && !tlast_blocked;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = (state == ST_PAY) && s_axis_tlast;

    assign s_fire = s_axis_tvalid && s_axis_tready;
    assign push   = s_fire && s_axis_tlast && push_want;
    assign entry  = {src_n, dst_n, seq_n, ack_n, flags_n, win_n, {doff_n, 2'b00}, plen_n, csum_ok, entry_err};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HDR;
            byte_idx  <= 5'd0;
            opt_left  <= 6'd0;
            drop_push <= 1'b0;
            src_r     <= 16'd0;
            dst_r     <= 16'd0;
            seq_r     <= 32'd0;
            ack_r     <= 32'd0;
            doff_r    <= 4'd0;
            flags_r   <= 8'd0;
            win_r     <= 16'd0;
            csum_acc  <= 32'd0;
            odd_byte  <= 1'b0;
            pay_cnt   <= 16'd0;
            drop_cnt  <= 16'd0;
        end else if (s_fire) begin
            if (s_axis_tlast) begin
                state     <= ST_HDR;
                byte_idx  <= 5'd0;
                opt_left  <= 6'd0;
                drop_push <= 1'b0;
                src_r     <= 16'd0;
                dst_r     <= 16'd0;
                seq_r     <= 32'd0;
                ack_r     <= 32'd0;
                doff_r    <= 4'd0;
                flags_r   <= 8'd0;
                win_r     <= 16'd0;
                csum_acc  <= 32'd0;
                odd_byte  <= 1'b0;
                pay_cnt   <= 16'd0;
                if (entry_err || !push_want) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end else begin
                src_r    <= src_n;
                dst_r    <= dst_n;
                seq_r    <= seq_n;
                ack_r    <= ack_n;
                doff_r   <= doff_n;
                flags_r  <= flags_n;
                win_r    <= win_n;
                csum_acc <= csum_nxt;
                odd_byte <= ~odd_byte;
                case (state)
                    ST_HDR: begin
                        byte_idx <= byte_idx + 5'd1;
                        if (byte_idx == 5'd12 && din[7:4] < 4'd5) begin
                            state     <= ST_DROP;
                            drop_push <= 1'b1;
                        end else if (hdr_end) begin
                            if (filter_hit) begin
                                state     <= ST_DROP;
                                drop_push <= 1'b0;
                            end else if (doff_r > 4'd5) begin
                                state    <= ST_OPT;
                                opt_left <= {doff_r - 4'd5, 2'b00};
                            end else begin
                                state <= ST_PAY;
                            end
                        end
                    end
                    ST_OPT: begin
                        opt_left <= opt_left - 6'd1;
                        if (opt_left == 6'd1) begin
                            state <= ST_PAY;
                        end
                    end
                    ST_PAY:  pay_cnt <= pay_inc;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= entry;
        end
    end

    assign meta_valid = (wr_ptr != rd_ptr);
    assign {meta_src_port, meta_dst_port, meta_seq_num, meta_ack_num, meta_flags, meta_window_size,
            meta_hdr_len, meta_payload_len, meta_checksum_ok, meta_err} =
           meta_valid ? mem[rd_ptr[ADDR_W-1:0]] : '0;

endmodule

// File: doc/tcp_rx_parser.md
TCP_RX_PARSER -- requirements
Module: tcp_rx_parser

Interface
REQ-001 Parameter DATA_WIDTH, default 8: stream width in bits; any value other than 8 SHALL cause an elaboration error.
REQ-002 Parameter META_DEPTH, default 4: metadata FIFO entries; power of two, >=2.
REQ-003 Parameter FILTER_EN, default 0: when 1, packets whose dst_port != FILTER_PORT are dropped.
REQ-004 Parameter FILTER_PORT, default 16'd80: accepted destination port when FILTER_EN=1.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 s_axis  axi_stream_if slave  8  TCP header+options+payload bytes; tdata/tvalid/tready/tlast.
REQ-009 m_axis  axi_stream_if master  8  payload bytes only; tlast marks final payload byte.
REQ-010 meta_valid  out  1  metadata FIFO head valid (FIFO not empty).
REQ-011 meta_ready  in  1  consumer pops head when meta_valid && meta_ready.
REQ-012 meta_src_port, meta_dst_port  out  16 each  header ports, big-endian assembled.
REQ-013 meta_seq_num, meta_ack_num  out  32 each  sequence/ack numbers.
REQ-014 meta_flags  out  8  header byte 13.
REQ-015 meta_window_size  out  16  window field.
REQ-016 meta_hdr_len  out  6  data offset x4 (bytes, 20..60).
REQ-017 meta_payload_len  out  16  bytes forwarded on m_axis for this packet.
REQ-018 meta_checksum_ok  out  1  one's-complement sum over all packet bytes folds to 16'hFFFF.
REQ-019 meta_err  out  1  packet malformed (truncated header/options or data offset <5).
REQ-020 drop_cnt  out  16  count of packets dropped (malformed or filtered), wraps at 16'hFFFF->0.

Function
REQ-021 States SHALL be HDR, OPT, PAYLOAD, DROP; every state returns to HDR on an accepted beat with tlast=1.
REQ-022 HDR: accept bytes 0..19 into header registers; at byte 12 capture doff=tdata[7:4]; doff<5 -> DROP (meta_err=1); after byte 19 -> OPT if doff>5, else PAYLOAD.
REQ-023 OPT: discard (doff-5)*4 bytes, include in checksum, then -> PAYLOAD.
REQ-024 FILTER_EN=1 and dst_port != FILTER_PORT at header end -> DROP; no metadata entry, drop_cnt++.
REQ-025 In HDR/OPT/DROP s_axis.tready=1 except on a tlast beat needing a FIFO push while FIFO full; m_axis.tvalid=0.
REQ-026 PAYLOAD: combinational pass-through, m_axis.tdata=s_axis.tdata, m_axis.tvalid=s_axis.tvalid, m_axis.tlast=s_axis.tlast, s_axis.tready=m_axis.tready (and FIFO not full when tlast).
REQ-027 Payload counter 16-bit, increments per forwarded byte, saturates at 16'hFFFF.
REQ-028 Checksum: 32-bit accumulator, even-index bytes high, odd low, odd total length pads low byte 0; end-around carry folded; checksum_ok evaluated including final byte.
REQ-029 Metadata pushed to FIFO on the tlast handshake of every non-filtered packet (including malformed), zero latency into FIFO; visible on meta_* next cycle.
REQ-030 tlast in HDR or OPT (truncated): push entry with meta_err=1, payload_len=0, unset fields 0; drop_cnt++.
REQ-031 Zero-length payload (tlast on last header/option byte): no m_axis beat; entry pushed with payload_len=0.
REQ-032 FIFO full at a push-needing tlast: hold s_axis.tready=0 until a pop frees an entry; simultaneous pop and push when full SHALL succeed in the same cycle.
REQ-033 meta_* outputs SHALL hold stable while meta_valid=1 and meta_ready=0.

Reset
REQ-034 rst_n=0 SHALL immediately set state HDR, FIFO empty, meta_valid=0, all meta_* 0, m_axis.tvalid=0, s_axis.tready=0, drop_cnt=0, accumulators/counters 0.
REQ-035 Reset mid-packet SHALL discard the partial packet; the first byte after release is header byte 0.

Verification
REQ-036 20-byte header (doff=5), 37-byte payload, valid checksum -> 37 m_axis bytes with tlast on 37th; meta_payload_len=37, meta_hdr_len=20, checksum_ok=1, err=0.
REQ-037 doff=8 (12 option bytes), 10-byte payload -> options not forwarded; meta_hdr_len=32, payload_len=10.
REQ-038 Header byte 5 corrupted after checksum generation -> checksum_ok=0, payload still forwarded intact.
REQ-039 tlast on byte 15 -> meta_err=1, payload_len=0, no m_axis beats, drop_cnt=1; byte 12=0x40 -> meta_err=1, whole packet dropped.
REQ-040 meta_ready=0, 5 back-to-back packets, META_DEPTH=4 -> 4 entries queued, 5th tlast stalled; one pop -> 5th accepted; FIFO order preserved.
REQ-041 FILTER_EN=1, FILTER_PORT=80: dst 443 -> no meta, no m_axis, drop_cnt+1; dst 80 -> normal; m_axis.tready toggled randomly -> no byte lost or duplicated.
